svpwm_gen: RTL

Space-vector PWM generator, directly downstream of the inverse Clarke stage in the FOC voltage path. It accepts one three-phase voltage sample (Va, Vb, Vc) per AXI-Stream beat and applies min/max zero-sequence injection, which is equivalent to SVPWM. It scales each phase to a compare value and drives three center-aligned complementary PWM pairs to the gate driver. New duties take effect only at the triangle-counter valley, so a PWM period never uses a mix of old and new compare values.

---
 rtl/svpwm_pkg.sv | 54 +++++
 rtl/svpwm_gen_if.sv | 12 +
 rtl/svpwm_deadtime.sv | 44 ++++
 rtl/svpwm_gen.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/svpwm_pkg.sv
// Shared definitions for the SVPWM generator: Q15 limits, AXI-Stream field
// offsets, FSM encodings and the min/max zero-sequence injection helpers.
package svpwm_pkg;

    localparam int TDATA_W   = 64;
    localparam int FIELD_W   = 16;
    localparam int VA_LSB    = 0;
    localparam int VB_LSB    = 16;
    localparam int VC_LSB    = 32;
    localparam int THETA_LSB = 48;

    localparam logic signed [16:0] MAX_LIM = 17'sd32767;
    localparam logic signed [16:0] MIN_LIM = -17'sd32767;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_MINMAX = 3'd1;
    localparam logic [2:0] ST_OFFSET = 3'd2;
    localparam logic [2:0] ST_SCALE  = 3'd3;
    localparam logic [2:0] ST_HOLD   = 3'd4;

    function automatic logic signed [16:0] max3(input logic signed [15:0] a,
                                                input logic signed [15:0] b,
                                                input logic signed [15:0] c);
        logic signed [15:0] m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return 17'(m);
    endfunction

    function automatic logic signed [16:0] min3(input logic signed [15:0] a,
                                                input logic signed [15:0] b,
                                                input logic signed [15:0] c);
        logic signed [15:0] m;
        m = a;
        if (b < m) m = b;
        if (c < m) m = c;
        return 17'(m);
    endfunction

    // Adds off = -((vmax+vmin)>>>1) with 18-bit headroom, then clamps to Q15.
    function automatic logic signed [16:0] injectOffset(input logic signed [15:0] v,
                                                        input logic signed [16:0] vmax,
                                                        input logic signed [16:0] vmin);
        logic signed [17:0] sum;
        logic signed [17:0] adj;
        sum = 18'(vmax) + 18'(vmin);
        adj = 18'(v) - (sum >>> 1);
        if (adj > 18'(MAX_LIM)) return MAX_LIM;
        if (adj < 18'(MIN_LIM)) return MIN_LIM;
        return 17'(adj);
    endfunction

endpackage

// File: rtl/svpwm_gen_if.sv
// AXI-Stream sample channel carrying one Va/Vb/Vc/Theta beat into svpwm_gen.
interface svpwm_axis_if;
    import svpwm_pkg::*;

    logic [TDATA_W-1:0] tdata;
    logic               tvalid;
    logic               tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);

endinterface

// File: rtl/svpwm_deadtime.sv
// Dead-time inserter: each gate output rises only after DEADTIME cycles of
// stable input, and drops immediately when the input leaves its level.
module svpwm_deadtime #(
    parameter int DEADTIME = 50
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic out_h,
    output logic out_l
);
    import svpwm_pkg::*;

    localparam int            CW   = $clog2(DEADTIME + 1);
    localparam logic [CW-1:0] DT_C = CW'(DEADTIME);

    logic          r_last;
    logic [CW-1:0] r_stable;
    logic [CW-1:0] w_stableNext;

    always_comb begin
        w_stableNext = r_stable;
        if (in != r_last) begin
            w_stableNext = '0;
        end else if (r_stable != DT_C) begin
            w_stableNext = r_stable + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last   <= 1'b0;
            r_stable <= '0;
            out_h    <= 1'b0;
            out_l    <= 1'b0;
        end else begin
            r_last   <= in;
            r_stable <= w_stableNext;
            out_h    <= in & (w_stableNext == DT_C);
            out_l    <= ~in & (w_stableNext == DT_C);
        end
    end

endmodule

// File: rtl/svpwm_gen.sv
// Space-vector PWM generator: min/max injection, duty scaling, valley-synchronous
// duty update and center-aligned complementary outputs. Define SVPWM_DEADTIME_EN for dead-time.
module svpwm_gen
    import svpwm_pkg::*;
#(
    parameter int PWM_PERIOD = 2500,
    parameter int CNT_W      = 16,
    parameter int DEADTIME   = 50
) (
    input  logic        clk,
    input  logic        reset,
    svpwm_axis_if.slave s_axis,
    output logic        pwm_ah,
    output logic        pwm_al,
    output logic        pwm_bh,
    output logic        pwm_bl,
    output logic        pwm_ch,
    output logic        pwm_cl,
    output logic        period_start
);

    localparam logic [CNT_W-1:0] PERIOD_C = CNT_W'(PWM_PERIOD);
    localparam logic [CNT_W-1:0] HALF_C   = CNT_W'(PWM_PERIOD / 2);

    logic [CNT_W-1:0]  r_cnt;
    logic              r_dirUp;
    logic              r_periodStart;
    logic [2:0]        r_state;
    logic signed [15:0] r_v [3];
    logic signed [16:0] r_vmax;
    logic signed [16:0] r_vmin;
    logic signed [16:0] r_adj [3];
    logic [CNT_W-1:0]  r_pend [3];
    logic [CNT_W-1:0]  r_act [3];
    logic [2:0]        w_raw;
    logic              w_accept;
    logic              w_unusedTheta;

    function automatic logic [CNT_W-1:0] scaleDuty(input logic signed [16:0] v);
        logic [16:0]      u;
        logic [CNT_W+16:0] p;
        u = 17'(v + 17'sd32768);
        p = (CNT_W+17)'(u) * (CNT_W+17)'(PERIOD_C);
        return CNT_W'(p >> 16);
    endfunction

    assign s_axis.tready = (r_state == ST_IDLE) & ~reset;
    assign w_accept      = s_axis.tvalid & s_axis.tready;
    assign w_unusedTheta = &{1'b0, s_axis.tdata[THETA_LSB +: FIELD_W]};
    assign period_start  = r_periodStart;

    // Triangle carrier: each endpoint occupies exactly one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt         <= '0;
            r_dirUp       <= 1'b1;
            r_periodStart <= 1'b0;
        end else begin
            r_periodStart <= (r_cnt == '0);
            if (r_cnt == PERIOD_C) begin
                r_cnt   <= PERIOD_C - 1'b1;
                r_dirUp <= 1'b0;
            end else if (r_cnt == '0) begin
                r_cnt   <= CNT_W'(1);
                r_dirUp <= 1'b1;
            end else if (r_dirUp) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_vmax  <= '0;
            r_vmin  <= '0;
            for (int k = 0; k < 3; k++) begin
                r_v[k]    <= '0;
                r_adj[k]  <= '0;
                r_pend[k] <= HALF_C;
                r_act[k]  <= HALF_C;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_v[0]  <= $signed(s_axis.tdata[VA_LSB +: FIELD_W]);
                        r_v[1]  <= $signed(s_axis.tdata[VB_LSB +: FIELD_W]);
                        r_v[2]  <= $signed(s_axis.tdata[VC_LSB +: FIELD_W]);
                        r_state <= ST_MINMAX;
                    end
                end
                ST_MINMAX: begin
                    r_vmax  <= max3(r_v[0], r_v[1], r_v[2]);
                    r_vmin  <= min3(r_v[0], r_v[1], r_v[2]);
                    r_state <= ST_OFFSET;
                end
                ST_OFFSET: begin
                    for (int k = 0; k < 3; k++) begin
                        r_adj[k] <= injectOffset(r_v[k], r_vmax, r_vmin);
                    end
                    r_state <= ST_SCALE;
                end
                ST_SCALE: begin
                    for (int k = 0; k < 3; k++) begin
                        r_pend[k] <= scaleDuty(r_adj[k]);
                    end
                    r_state <= ST_HOLD;
                end
                ST_HOLD: begin
                    // Swap only at the valley so no carrier period mixes old and new duties.
                    if (r_cnt == '0) begin
                        for (int k = 0; k < 3; k++) begin
                            r_act[k] <= r_pend[k];
                        end
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_raw = '0;
        for (int k = 0; k < 3; k++) begin
            w_raw[k] = (r_act[k] >= PERIOD_C) | (r_cnt < r_act[k]);
        end
    end

`ifdef SVPWM_DEADTIME_EN
    svpwm_deadtime #(.DEADTIME(DEADTIME)) u_dtA (
        .clk(clk), .reset(reset), .in(w_raw[0]), .out_h(pwm_ah), .out_l(pwm_al)
    );
    svpwm_deadtime #(.DEADTIME(DEADTIME)) u_dtB (
        .clk(clk), .reset(reset), .in(w_raw[1]), .out_h(pwm_bh), .out_l(pwm_bl)
    );
    svpwm_deadtime #(.DEADTIME(DEADTIME)) u_dtC (
        .clk(clk), .reset(reset), .in(w_raw[2]), .out_h(pwm_ch), .out_l(pwm_cl)
    );
`else
    logic [5:0] r_gate;
    logic       w_unusedDeadtime;

    assign w_unusedDeadtime = (DEADTIME > 0);
    assign {pwm_cl, pwm_ch, pwm_bl, pwm_bh, pwm_al, pwm_ah} = r_gate;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_gate <= '0;
        end else begin
            r_gate <= {~w_raw[2], w_raw[2], ~w_raw[1], w_raw[1], ~w_raw[0], w_raw[0]};
        end
    end
`endif

endmodule
